psa_interval_timer: RTL and testbench
=====================================

Name: psa_interval_timer

Overview:
- 8253-compatible three-channel interval timer, binary counting only.
- Sits directly downstream of the PCG/timer address decoder and replaces the discrete 8253 on the board.
- Selected by the decoder's active-low timer chip-select (Z80 I/O 0Ch-0Fh); channel gates come from decoder control-register bits.
- OUT pins drive the sound and interrupt logic.

Parameters:
- TICK_DIV, 1: number of i_CNT_EN pulses per count decrement. Values 1..16; 1 means every enabled tick.

Ports:
- i_CLK  in  1  system clock; the only clock.
- i_RST  in  1  asynchronous, active-high reset.
- i_nCS  in  1  chip select from the decoder, active low.
- i_nRD  in  1  Z80 read strobe, active low.
- i_nWR  in  1  Z80 write strobe, active low.
- i_A  in  2  register select: 0-2 = counter 0-2, 3 = control word.
- i_D  in  8  write data.
- i_CNT_EN  in  1  one-i_CLK-wide count tick (counter clock equivalent).
- i_GATE  in  3  per-channel gate, sampled on i_CLK.
- o_D  out  8  read data.
- o_DOE  out  1  read-data enable; high while !i_nCS & !i_nRD & i_A!=3.
- o_OUT  out  3  channel outputs.

Behaviour:
- Reset: all counters idle (no count loaded); o_OUT=3'b000; o_D=0; o_DOE=0; all latches cleared; every RW flip-flop points to LSB.
- Write detect: a write is accepted once, on the first i_CLK edge where !i_nCS & !i_nWR after that condition was false. A held strobe causes no repeat.
- Read completion: the rising edge of (!i_nCS & !i_nRD), seen one cycle later, advances the byte flip-flop.
- Control word (A=3):
  - D7:6 = SC; 11 is ignored entirely.
  - D5:4 = RW: 00 latch, 01 LSB, 10 MSB, 11 LSB then MSB.
  - D3:1 = mode: 000 → mode 0; x10 → mode 2; x11 → mode 3; all other codes → mode 0.
  - D0 (BCD) is ignored.
- Non-latch control word: channel goes idle; byte flip-flop goes to LSB; OUT is set to 0 (mode 0) or 1 (modes 2/3) on the same edge.
- Latch command (RW=00): snapshots the live count into the output latch. Reads return the latch until all bytes are read per RW mode. Further latch commands are ignored until then.
- Count write:
  - RW=01 sets MSB=0; RW=10 sets LSB=0; RW=11 needs two writes.
  - Count 0 means 65536.
  - Loading the full count arms the channel; the value enters the counter on the next divided tick.
- Mode 0:
  - Writing the first byte drives OUT=0 immediately and pauses counting.
  - After load, decrement on each tick while GATE=1.
  - OUT goes to 1 on the tick the count reaches 0 and stays 1.
  - The counter keeps wrapping 0 → FFFFh with OUT unchanged.
- Mode 2 (period N):
  - OUT=1; OUT=0 for exactly one tick when count=1, then reload N and OUT=1.
  - GATE=0 forces OUT=1 and holds the count.
  - GATE rising edge reloads N on the next tick.
  - A new count written mid-cycle takes effect at the next reload.
- Mode 3 (period N): OUT high for ceil(N/2) ticks, low for floor(N/2) ticks, repeating. GATE behaves as in mode 2.
- Divided tick: an internal counter counts i_CNT_EN pulses; every TICK_DIV-th pulse is a tick. The counter clears on reset only.
- Priority: a control word or count write to a channel on the same edge as a tick wins; that channel ignores the tick.
- Read data: o_D = LSB or MSB of (latch if latched, else live count), selected by RW mode and the byte flip-flop. Combinational from registers.
- Reset mid-count: state returns to reset values asynchronously; no OUT glitch beyond the forced 0.

Test Plan:
- Mode 0, TICK_DIV=1: write 10h to A3, 05h to A0; GATE0=1; pulse i_CNT_EN → OUT0 low; OUT0 rises on the 6th tick after the write (1 load + 5 decrements) and stays high.
- Mode 2: control 74h (ch1, LSB/MSB, mode 2), count 0004h → OUT1 low for 1 tick in every 4, steady. GATE1=0 for 3 ticks → OUT1 held high, period restarts 4 ticks after GATE1 rises.
- Mode 3, N=5: OUT2 high 3 ticks, low 2 ticks, repeating. With N=4: 2/2.
- Latch: load 1234h in mode 2; issue latch 00h on ch0 while ticking; two reads return the latched LSB then MSB; the value is unchanged by later ticks; a following read returns the live count.
- Repeated strobe: hold i_nWR low for 8 cycles writing A0 in RW=11 → only the LSB is taken; the next write supplies the MSB.
- Reset mid-operation: assert i_RST during mode 3 counting → o_OUT=000 immediately; after release, no counting until a new control word and count are written.

Source files
------------

// File: rtl/psa_interval_timer.sv
// 8253-compatible three-channel interval timer, binary counting only.
// Modes 0, 2 and 3; bus writes and reads are edge-detected on i_CLK.
module psa_interval_timer #(
    parameter int TICK_DIV = 1
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_nCS,
    input  logic       i_nRD,
    input  logic       i_nWR,
    input  logic [1:0] i_A,
    input  logic [7:0] i_D,
    input  logic       i_CNT_EN,
    input  logic [2:0] i_GATE,
    output logic [7:0] o_D,
    output logic       o_DOE,
    output logic [2:0] o_OUT
);

    typedef enum logic [1:0] {
        M0 = 2'd0,
        M2 = 2'd2,
        M3 = 2'd3
    } mode_t;

    localparam logic [3:0] DIV_MAX = 4'(TICK_DIV - 1);

    logic        wr_q, rd_q;
    logic [3:0]  div_cnt;
    mode_t       mode [3];
    logic [1:0]  rw [3];
    logic [15:0] count [3];
    logic [15:0] reload [3];
    logic [15:0] latch [3];
    logic [7:0]  lsb_hold [3];
    logic [2:0]  armed, running, latched, wr_msb, rd_msb;
    logic [2:0]  gate_q, gate_pend, out_r;

    logic        wr_act, rd_act, wr_stb, rd_stb, tick;
    logic [2:0]  ctl_wr, cnt_wr, cw_full, hit;
    logic [15:0] cw_val [3];
    logic [15:0] nxt [3];
    logic [2:0]  m3_out;

    function automatic mode_t dec_mode(input logic [2:0] m);
        if (m[1:0] == 2'b10) return M2;
        if (m[1:0] == 2'b11) return M3;
        return M0;
    endfunction

    // A stored 0 stands for 65536 in both operands.
    function automatic logic m3_high(input logic [15:0] c, input logic [15:0] n);
        logic [16:0] c17, n17;
        c17 = (c == 16'd0) ? 17'h10000 : {1'b0, c};
        n17 = (n == 16'd0) ? 17'h10000 : {1'b0, n};
        return c17 > (n17 >> 1);
    endfunction

    assign wr_act = !i_nCS && !i_nWR;
    assign rd_act = !i_nCS && !i_nRD;
    assign wr_stb = wr_act && !wr_q;
    assign rd_stb = rd_act && !rd_q;
    assign tick   = i_CNT_EN && (div_cnt == DIV_MAX);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ctl_wr[i]  = wr_stb && (i_A == 2'd3) && (i_D[7:6] == 2'(i));
            cnt_wr[i]  = wr_stb && (i_A == 2'(i)) && (rw[i] != 2'b00);
            hit[i]     = ctl_wr[i] || cnt_wr[i];
            cw_full[i] = 1'b0;
            cw_val[i]  = 16'd0;
            unique case (rw[i])
                2'b01: begin
                    cw_full[i] = 1'b1;
                    cw_val[i]  = {8'h00, i_D};
                end
                2'b10: begin
                    cw_full[i] = 1'b1;
                    cw_val[i]  = {i_D, 8'h00};
                end
                2'b11: begin
                    cw_full[i] = wr_msb[i];
                    cw_val[i]  = {i_D, lsb_hold[i]};
                end
                default: ;
            endcase
            nxt[i]    = (count[i] == 16'd1) ? reload[i] : count[i] - 16'd1;
            m3_out[i] = m3_high(nxt[i], reload[i]);
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            div_cnt   <= 4'd0;
            armed     <= 3'b000;
            running   <= 3'b000;
            latched   <= 3'b000;
            wr_msb    <= 3'b000;
            rd_msb    <= 3'b000;
            gate_q    <= 3'b000;
            gate_pend <= 3'b000;
            out_r     <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                mode[i]     <= M0;
                rw[i]       <= 2'b00;
                count[i]    <= 16'd0;
                reload[i]   <= 16'd0;
                latch[i]    <= 16'd0;
                lsb_hold[i] <= 8'd0;
            end
        end else begin
            wr_q <= wr_act;
            rd_q <= rd_act;
            if (i_CNT_EN)
                div_cnt <= (div_cnt == DIV_MAX) ? 4'd0 : div_cnt + 4'd1;
            for (int i = 0; i < 3; i++) begin
                gate_q[i] <= i_GATE[i];
                if (mode[i] != M0 && i_GATE[i] && !gate_q[i])
                    gate_pend[i] <= 1'b1;
                if (mode[i] != M0 && running[i] && !i_GATE[i])
                    out_r[i] <= 1'b1;

                if (tick && !hit[i]) begin
                    if (armed[i]) begin
                        count[i]     <= reload[i];
                        armed[i]     <= 1'b0;
                        running[i]   <= 1'b1;
                        gate_pend[i] <= 1'b0;
                        if (mode[i] != M0) out_r[i] <= 1'b1;
                    end else if (running[i] && i_GATE[i]) begin
                        if (mode[i] == M0) begin
                            count[i] <= count[i] - 16'd1;
                            if (count[i] == 16'd1) out_r[i] <= 1'b1;
                        end else if (gate_pend[i]) begin
                            count[i]     <= reload[i];
                            out_r[i]     <= 1'b1;
                            gate_pend[i] <= 1'b0;
                        end else begin
                            count[i] <= nxt[i];
                            out_r[i] <= (mode[i] == M2) ? (nxt[i] != 16'd1) : m3_out[i];
                        end
                    end
                end

                if (rd_stb && i_A == 2'(i)) begin
                    if (rw[i] == 2'b11) begin
                        rd_msb[i] <= !rd_msb[i];
                        if (latched[i] && rd_msb[i]) latched[i] <= 1'b0;
                    end else if (latched[i]) begin
                        latched[i] <= 1'b0;
                    end
                end

                if (ctl_wr[i]) begin
                    if (i_D[5:4] == 2'b00) begin
                        if (!latched[i]) begin
                            latched[i] <= 1'b1;
                            latch[i]   <= count[i];
                        end
                    end else begin
                        rw[i]        <= i_D[5:4];
                        mode[i]      <= dec_mode(i_D[3:1]);
                        running[i]   <= 1'b0;
                        armed[i]     <= 1'b0;
                        wr_msb[i]    <= 1'b0;
                        rd_msb[i]    <= 1'b0;
                        latched[i]   <= 1'b0;
                        gate_pend[i] <= 1'b0;
                        out_r[i]     <= (dec_mode(i_D[3:1]) != M0);
                    end
                end else if (cnt_wr[i]) begin
                    if (rw[i] == 2'b11) wr_msb[i] <= !wr_msb[i];
                    if (!wr_msb[i]) lsb_hold[i] <= i_D;
                    // Mode 0 stops on any byte; modes 2/3 keep running until reload.
                    if (mode[i] == M0) begin
                        out_r[i]   <= 1'b0;
                        running[i] <= 1'b0;
                        armed[i]   <= 1'b0;
                    end
                    if (cw_full[i]) begin
                        reload[i] <= cw_val[i];
                        if (mode[i] == M0 || !running[i]) armed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        logic [15:0] val;
        logic        msb;
        o_D   = 8'd0;
        o_DOE = !i_nCS && !i_nRD && (i_A != 2'd3);
        val   = 16'd0;
        msb   = 1'b0;
        if (i_A != 2'd3) begin
            val = latched[i_A] ? latch[i_A] : count[i_A];
            msb = (rw[i_A] == 2'b10) || (rw[i_A] == 2'b11 && rd_msb[i_A]);
            o_D = msb ? val[15:8] : val[7:0];
        end
    end

    assign o_OUT = out_r;

endmodule

// File: tb/tb_psa_interval_timer.sv
// Bench for psa_interval_timer: vector table for modes 0/2/3 plus
// hand sequences for latch, held strobe, reset and tick division.
module tb_psa_interval_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ncs = 1'b1;
    logic       nrd = 1'b1;
    logic       nwr = 1'b1;
    logic [1:0] a = 2'd0;
    logic [7:0] d = 8'd0;
    logic       cnt_en = 1'b0;
    logic [2:0] gate = 3'b111;
    logic [7:0] od, od3;
    logic       doe, doe3;
    logic [2:0] out, out3;

    int checks = 0;
    int failures = 0;

    typedef enum {OP_WR, OP_TICK, OP_GATE} op_e;
    typedef struct {
        op_e        op;
        logic [1:0] a;
        logic [7:0] d;
        logic [2:0] mask;
        logic [2:0] exp;
    } vec_t;

    vec_t       vecs [$];
    logic [2:0] sb_out [$];
    logic [7:0] sb_dat [$];

    always #5 clk = ~clk;

    psa_interval_timer #(.TICK_DIV(1)) dut (
        .i_CLK(clk), .i_RST(rst), .i_nCS(ncs), .i_nRD(nrd), .i_nWR(nwr),
        .i_A(a), .i_D(d), .i_CNT_EN(cnt_en), .i_GATE(gate),
        .o_D(od), .o_DOE(doe), .o_OUT(out)
    );

    psa_interval_timer #(.TICK_DIV(3)) dut3 (
        .i_CLK(clk), .i_RST(rst), .i_nCS(ncs), .i_nRD(nrd), .i_nWR(nwr),
        .i_A(a), .i_D(d), .i_CNT_EN(cnt_en), .i_GATE(gate),
        .o_D(od3), .o_DOE(doe3), .o_OUT(out3)
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] aa, input logic [7:0] dd);
        @(negedge clk);
        ncs = 1'b0; nwr = 1'b0; a = aa; d = dd;
        @(negedge clk);
        ncs = 1'b1; nwr = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        cnt_en = 1'b1;
        @(negedge clk);
        cnt_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd_chk(input string name, input logic [1:0] aa, input logic [7:0] exp);
        logic [7:0] v;
        logic       e;
        sb_dat.push_back(exp);
        @(negedge clk);
        ncs = 1'b0; nrd = 1'b0; a = aa;
        #1;
        v = od;
        e = doe;
        @(negedge clk);
        ncs = 1'b1; nrd = 1'b1;
        cmp(name, 16'(v), 16'(sb_dat.pop_front()));
        cmp({name, "_doe"}, 16'(e), 16'(aa != 2'd3));
    endtask

    function automatic void add(op_e op, logic [1:0] aa, logic [7:0] dd,
                                logic [2:0] mask, logic [2:0] exp);
        vec_t v;
        v.op = op; v.a = aa; v.d = dd; v.mask = mask; v.exp = exp;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // mode 0, ch0, count 5: rises on the 6th tick
        add(OP_WR, 2'd3, 8'h10, 3'b001, 3'b000);
        add(OP_WR, 2'd0, 8'h05, 3'b001, 3'b000);
        for (int t = 1; t <= 8; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b001, (t >= 6) ? 3'b001 : 3'b000);
        // mode 2, ch1, N=4, then a 3-tick gate-low window
        add(OP_WR, 2'd3, 8'h74, 3'b010, 3'b010);
        add(OP_WR, 2'd1, 8'h04, 3'b010, 3'b010);
        add(OP_WR, 2'd1, 8'h00, 3'b010, 3'b010);
        for (int t = 1; t <= 12; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b010, (t % 4 == 0) ? 3'b000 : 3'b010);
        add(OP_GATE, 2'd0, 8'h05, 3'b010, 3'b010);
        for (int t = 1; t <= 3; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b010, 3'b010);
        add(OP_GATE, 2'd0, 8'h07, 3'b010, 3'b010);
        for (int t = 1; t <= 5; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b010, (t == 4) ? 3'b000 : 3'b010);
        // mode 3, ch2, N=5 (3/2) then N=4 (2/2) taking effect at reload
        add(OP_WR, 2'd3, 8'hB6, 3'b100, 3'b100);
        add(OP_WR, 2'd2, 8'h05, 3'b100, 3'b100);
        add(OP_WR, 2'd2, 8'h00, 3'b100, 3'b100);
        for (int t = 1; t <= 11; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b100, ((t - 1) % 5 < 3) ? 3'b100 : 3'b000);
        add(OP_WR, 2'd2, 8'h04, 3'b100, 3'b100);
        add(OP_WR, 2'd2, 8'h00, 3'b100, 3'b100);
        for (int t = 12; t <= 19; t++)
            add(OP_TICK, 2'd0, 8'h00, 3'b100, ((t - 12) % 4 < 2) ? 3'b100 : 3'b000);

        repeat (2) @(negedge clk);
        cmp("rst_out", 16'(out), 16'h0);
        cmp("rst_d", 16'(od), 16'h0);
        cmp("rst_doe", 16'(doe), 16'h0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            sb_out.push_back(vecs[i].exp & vecs[i].mask);
            unique case (vecs[i].op)
                OP_WR:   wr(vecs[i].a, vecs[i].d);
                OP_TICK: tick();
                OP_GATE: begin
                    @(negedge clk);
                    gate = vecs[i].d[2:0];
                    @(negedge clk);
                end
                default: ;
            endcase
            cmp($sformatf("vec%0d", i), 16'(out & vecs[i].mask), 16'(sb_out.pop_front()));
        end

        // latch on ch0, mode 2, count 1234h
        wr(2'd3, 8'h34);
        wr(2'd0, 8'h34);
        wr(2'd0, 8'h12);
        ticks(4);
        wr(2'd3, 8'h00);
        ticks(2);
        wr(2'd3, 8'h00);
        tick();
        rd_chk("ctl_rd", 2'd3, 8'h00);
        rd_chk("latch_lsb", 2'd0, 8'h31);
        rd_chk("latch_msb", 2'd0, 8'h12);
        rd_chk("live_lsb", 2'd0, 8'h2E);
        rd_chk("live_msb", 2'd0, 8'h12);

        // held write strobe on ch1 takes only the LSB
        wr(2'd3, 8'h70);
        cmp("m0_arm_out1", 16'(out[1]), 16'h0);
        @(negedge clk);
        ncs = 1'b0; nwr = 1'b0; a = 2'd1; d = 8'h07;
        repeat (8) @(negedge clk);
        ncs = 1'b1; nwr = 1'b1;
        wr(2'd1, 8'h00);
        tick();
        rd_chk("hold_lsb", 2'd1, 8'h07);
        rd_chk("hold_msb", 2'd1, 8'h00);
        ticks(6);
        cmp("hold_out_early", 16'(out[1]), 16'h0);
        tick();
        cmp("hold_out_tc", 16'(out[1]), 16'h1);

        // reset in the middle of mode 3 on ch2
        ticks(2);
        cmp("pre_rst_out2", 16'(out[2]), 16'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        cmp("async_rst_out", 16'(out), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        ticks(3);
        cmp("idle_out", 16'(out), 16'h0);
        rd_chk("idle_cnt", 2'd2, 8'h00);
        wr(2'd3, 8'hB6);
        cmp("reprog_out2", 16'(out[2]), 16'h1);
        ticks(2);
        rd_chk("noload_lsb", 2'd2, 8'h00);
        rd_chk("noload_msb", 2'd2, 8'h00);
        wr(2'd2, 8'h04);
        wr(2'd2, 8'h00);
        tick();
        rd_chk("load_lsb", 2'd2, 8'h04);
        rd_chk("load_msb", 2'd2, 8'h00);

        // TICK_DIV=3 needs three enable pulses per tick
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(2'd3, 8'h10);
        wr(2'd0, 8'h02);
        ticks(3);
        cmp("div1_out0", 16'(out[0]), 16'h1);
        cmp("div3_out0_p3", 16'(out3[0]), 16'h0);
        ticks(5);
        cmp("div3_out0_p8", 16'(out3[0]), 16'h0);
        tick();
        cmp("div3_out0_p9", 16'(out3[0]), 16'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
